// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, major opcodes, FSM states.
// The SLL/SLLI decode is present only when ALU_SLL_EN is defined (see alu_decode).
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response bus between the issue stage (master) and alu_issue_ctrl (slave).
interface alu_issue_ctrl_if;

    // Valid/ready: a transfer occurs on a rising clk edge where valid and ready are both 1.
    // The sender holds valid and payload stable until that edge; ready never waits on valid.
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic        req_funct7_5;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_imm;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_taken;
    logic        rsp_illegal;

    modport master (
        output req_valid, req_opcode, req_funct3, req_funct7_5, req_rs1, req_rs2, req_imm,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_taken, rsp_illegal
    );

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_funct7_5, req_rs1, req_rs2, req_imm,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_taken, rsp_illegal
    );

endinterface

// File: rtl/alu_decode.sv
// Combinational instruction decode to ALU control code and operand/branch flags.
// SLL and SLLI are legal only when ALU_SLL_EN is defined.
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
`ifdef ALU_SLL_EN
    input  logic [6:0] imm_hi,
`endif
    output logic [2:0] alu_control,
    output logic       use_imm,
    output logic       is_branch,
    output logic       branch_ne,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        use_imm     = 1'b0;
        is_branch   = 1'b0;
        branch_ne   = 1'b0;
        illegal     = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct3)
                    3'b000: begin
                        illegal     = 1'b0;
                        alu_control = funct7_5 ? ALU_SUB : ALU_ADD;
                    end
                    3'b111: if (!funct7_5) begin illegal = 1'b0; alu_control = ALU_AND; end
                    3'b110: if (!funct7_5) begin illegal = 1'b0; alu_control = ALU_OR;  end
                    3'b010: if (!funct7_5) begin illegal = 1'b0; alu_control = ALU_SLT; end
`ifdef ALU_SLL_EN
                    3'b001: if (!funct7_5) begin illegal = 1'b0; alu_control = ALU_SLL; end
`endif
                    default: ;
                endcase
            end
            OP_ITYPE: begin
                use_imm = 1'b1;
                case (funct3)
                    3'b000: begin illegal = 1'b0; alu_control = ALU_ADD; end
                    3'b111: begin illegal = 1'b0; alu_control = ALU_AND; end
                    3'b110: begin illegal = 1'b0; alu_control = ALU_OR;  end
                    3'b010: begin illegal = 1'b0; alu_control = ALU_SLT; end
`ifdef ALU_SLL_EN
                    3'b001: if (imm_hi == 7'd0) begin illegal = 1'b0; alu_control = ALU_SLL; end
`endif
                    default: ;
                endcase
            end
            OP_BRANCH: begin
                is_branch   = 1'b1;
                alu_control = ALU_SUB;
                case (funct3)
                    3'b000: illegal = 1'b0;
                    3'b001: begin illegal = 1'b0; branch_ne = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue front end: accept one instruction, run it through the external ALU, return a response.
// Build option ALU_SLL_EN enables SLL/SLLI decoding.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus,
    output logic [31:0]       alu_src_a,
    output logic [31:0]       alu_src_b,
    output logic [2:0]        alu_control,
    input  logic [31:0]       alu_result,
    input  logic              alu_zero,
    output state_t            state_dbg
);

    state_t     state, state_nxt;
    logic [2:0] dec_control;
    logic       dec_use_imm, dec_is_branch, dec_branch_ne, dec_illegal;
    logic       is_branch_q, branch_ne_q;
    logic       accept;

    alu_decode u_decode (
        .opcode      (bus.req_opcode),
        .funct3      (bus.req_funct3),
        .funct7_5    (bus.req_funct7_5),
`ifdef ALU_SLL_EN
        .imm_hi      (bus.req_imm[11:5]),
`endif
        .alu_control (dec_control),
        .use_imm     (dec_use_imm),
        .is_branch   (dec_is_branch),
        .branch_ne   (dec_branch_ne),
        .illegal     (dec_illegal)
    );

    assign accept        = bus.req_valid && (state == IDLE);
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign state_dbg     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = dec_illegal ? RESP : EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Illegal requests leave the ALU operand registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_src_a       <= '0;
            alu_src_b       <= '0;
            alu_control     <= ALU_ADD;
            is_branch_q     <= 1'b0;
            branch_ne_q     <= 1'b0;
            bus.rsp_result  <= '0;
            bus.rsp_taken   <= 1'b0;
            bus.rsp_illegal <= 1'b0;
        end else if (accept) begin
            if (dec_illegal) begin
                bus.rsp_illegal <= 1'b1;
                bus.rsp_result  <= '0;
                bus.rsp_taken   <= 1'b0;
            end else begin
                alu_src_a       <= bus.req_rs1;
                alu_src_b       <= dec_use_imm ? bus.req_imm : bus.req_rs2;
                alu_control     <= dec_control;
                is_branch_q     <= dec_is_branch;
                branch_ne_q     <= dec_branch_ne;
                bus.rsp_illegal <= 1'b0;
            end
        end else if (state == EXEC) begin
            bus.rsp_result <= alu_result;
            bus.rsp_taken  <= is_branch_q && (branch_ne_q ^ alu_zero);
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases from the test plan plus random instructions.
// Honours ALU_SLL_EN the same way as the design build.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

`ifdef ALU_SLL_EN
    localparam bit SLL_EN = 1'b1;
`else
    localparam bit SLL_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus_if ();
    logic [31:0] alu_src_a, alu_src_b, alu_result;
    logic [2:0]  alu_control;
    logic        alu_zero;
    state_t      state_dbg;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if.slave),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .state_dbg   (state_dbg)
    );

    // external combinational ALU
    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'b000:  alu_result = alu_src_a + alu_src_b;
            3'b001:  alu_result = alu_src_a - alu_src_b;
            3'b010:  alu_result = alu_src_a & alu_src_b;
            3'b011:  alu_result = alu_src_a | alu_src_b;
            3'b100:  alu_result = alu_src_a << alu_src_b[4:0];
            3'b101:  alu_result = ($signed(alu_src_a) < $signed(alu_src_b)) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    // scoreboard
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_src_a = '0;
    logic [31:0] m_src_b = '0;
    logic [2:0]  m_ctrl  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic string mnemonic(input logic [6:0] op, input logic [2:0] f3,
                                       input logic f7, input logic [31:0] imm);
        string m;
        m = "ILL";
        if (op == 7'b0110011) begin
            if (f3 == 3'd0)                m = f7 ? "SUB" : "ADD";
            else if (!f7 && f3 == 3'd7)    m = "AND";
            else if (!f7 && f3 == 3'd6)    m = "OR";
            else if (!f7 && f3 == 3'd2)    m = "SLT";
            else if (!f7 && f3 == 3'd1 && SLL_EN) m = "SLL";
        end else if (op == 7'b0010011) begin
            if (f3 == 3'd0)      m = "ADDI";
            else if (f3 == 3'd7) m = "ANDI";
            else if (f3 == 3'd6) m = "ORI";
            else if (f3 == 3'd2) m = "SLTI";
            else if (f3 == 3'd1 && imm[11:5] == 7'd0 && SLL_EN) m = "SLLI";
        end else if (op == 7'b1100011) begin
            if (f3 == 3'd0)      m = "BEQ";
            else if (f3 == 3'd1) m = "BNE";
        end
        return m;
    endfunction

    task automatic idle_inputs();
        bus_if.req_valid    = 1'b0;
        bus_if.req_opcode   = 7'($urandom_range(0, 127));
        bus_if.req_funct3   = 3'($urandom_range(0, 7));
        bus_if.req_funct7_5 = 1'($urandom_range(0, 1));
        bus_if.req_rs1      = $urandom;
        bus_if.req_rs2      = $urandom;
        bus_if.req_imm      = $urandom;
    endtask

    // driver + response checks for one transaction
    task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input int stall);
        string       mn;
        logic [31:0] res, b, hold;
        logic [2:0]  code;
        logic        taken, legal;
        mn    = mnemonic(op, f3, f7, imm);
        legal = (mn != "ILL");
        b     = (op == 7'b0010011) ? imm : rs2;
        res   = '0;
        taken = 1'b0;
        code  = 3'd0;
        case (mn)
            "ADD", "ADDI": begin res = rs1 + b; code = 3'd0; end
            "SUB":         begin res = rs1 - b; code = 3'd1; end
            "AND", "ANDI": begin res = rs1 & b; code = 3'd2; end
            "OR",  "ORI":  begin res = rs1 | b; code = 3'd3; end
            "SLL", "SLLI": begin res = rs1 << b[4:0]; code = 3'd4; end
            "SLT", "SLTI": begin res = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0; code = 3'd5; end
            "BEQ":         begin res = rs1 - rs2; code = 3'd1; taken = (rs1 == rs2); end
            "BNE":         begin res = rs1 - rs2; code = 3'd1; taken = (rs1 != rs2); end
            default: ;
        endcase

        @(negedge clk);
        check({mn, " req_ready idle"}, 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid    = 1'b1;
        bus_if.req_opcode   = op;
        bus_if.req_funct3   = f3;
        bus_if.req_funct7_5 = f7;
        bus_if.req_rs1      = rs1;
        bus_if.req_rs2      = rs2;
        bus_if.req_imm      = imm;
        bus_if.rsp_ready    = 1'($urandom_range(0, 1));
        exp_q.push_back(res);
        if (legal) begin
            m_src_a = rs1;
            m_src_b = b;
            m_ctrl  = code;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        if (legal) begin
            check({mn, " exec rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
            check({mn, " exec req_ready"}, 32'(bus_if.req_ready), 32'd0);
            check({mn, " alu_src_a"}, alu_src_a, m_src_a);
            check({mn, " alu_src_b"}, alu_src_b, m_src_b);
            check({mn, " alu_control"}, 32'(alu_control), 32'(m_ctrl));
            @(negedge clk);
        end
        hold = exp_q.pop_front();
        check({mn, " rsp_valid"}, 32'(bus_if.rsp_valid), 32'd1);
        check({mn, " resp req_ready"}, 32'(bus_if.req_ready), 32'd0);
        check({mn, " rsp_result"}, bus_if.rsp_result, hold);
        check({mn, " rsp_taken"}, 32'(bus_if.rsp_taken), 32'(taken));
        check({mn, " rsp_illegal"}, 32'(bus_if.rsp_illegal), 32'(!legal));
        check({mn, " resp alu_src_a"}, alu_src_a, m_src_a);
        check({mn, " resp alu_src_b"}, alu_src_b, m_src_b);
        check({mn, " resp alu_control"}, 32'(alu_control), 32'(m_ctrl));
        bus_if.rsp_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({mn, " stall rsp_valid"}, 32'(bus_if.rsp_valid), 32'd1);
            check({mn, " stall req_ready"}, 32'(bus_if.req_ready), 32'd0);
            check({mn, " stall rsp_result"}, bus_if.rsp_result, hold);
            check({mn, " stall rsp_taken"}, 32'(bus_if.rsp_taken), 32'(taken));
            check({mn, " stall rsp_illegal"}, 32'(bus_if.rsp_illegal), 32'(!legal));
        end
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        check({mn, " done rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
        check({mn, " done req_ready"}, 32'(bus_if.req_ready), 32'd1);
        bus_if.rsp_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"},   32'(bus_if.req_ready),   32'd1);
        check({tag, " rsp_valid"},   32'(bus_if.rsp_valid),   32'd0);
        check({tag, " rsp_result"},  bus_if.rsp_result,       32'd0);
        check({tag, " rsp_taken"},   32'(bus_if.rsp_taken),   32'd0);
        check({tag, " rsp_illegal"}, 32'(bus_if.rsp_illegal), 32'd0);
        check({tag, " alu_src_a"},   alu_src_a,               32'd0);
        check({tag, " alu_src_b"},   alu_src_b,               32'd0);
        check({tag, " alu_control"}, 32'(alu_control),        32'd0);
    endtask

    // reset pulse while the request sits in EXEC
    task automatic reset_in_exec();
        @(negedge clk);
        bus_if.req_valid    = 1'b1;
        bus_if.req_opcode   = OP_RTYPE;
        bus_if.req_funct3   = 3'd0;
        bus_if.req_funct7_5 = 1'b0;
        bus_if.req_rs1      = 32'd100;
        bus_if.req_rs2      = 32'd23;
        bus_if.req_imm      = '0;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("pre-reset alu_src_a", alu_src_a, 32'd100);
        rst_n = 1'b0;
        #1;
        m_src_a = '0;
        m_src_b = '0;
        m_ctrl  = '0;
        exp_q.delete();
        check_all_zero("reset in exec");
        bus_if.rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset hold rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        bus_if.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  op;
        logic [11:0] i12;
        logic [31:0] r1, r2;
        idle_inputs();
        bus_if.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after release");

        run_txn(OP_RTYPE, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 0);
        run_txn(OP_BRANCH, 3'd1, 1'b0, 32'h10, 32'h10, 32'd0, 0);
        run_txn(OP_BRANCH, 3'd0, 1'b0, 32'h10, 32'h10, 32'd0, 1);
        run_txn(OP_ITYPE, 3'd1, 1'b0, 32'd1, 32'd0, 32'd4, 0);
        run_txn(7'b0000011, 3'd0, 1'b0, 32'd9, 32'd3, 32'd8, 0);
        run_txn(OP_RTYPE, 3'd7, 1'b1, 32'hF0F0, 32'h0FF0, 32'd0, 2);
        run_txn(OP_ITYPE, 3'd1, 1'b0, 32'd3, 32'd0, 32'h0000_0024, 0);
        run_txn(OP_RTYPE, 3'd0, 1'b1, 32'd3, 32'd10, 32'd0, 5);
        run_txn(OP_ITYPE, 3'd2, 1'b0, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 0);

        reset_in_exec();
        run_txn(OP_RTYPE, 3'd6, 1'b0, 32'hA000_0005, 32'h0300_0030, 32'd0, 1);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = OP_RTYPE;
                4, 5, 6:    op = OP_ITYPE;
                7, 8:       op = OP_BRANCH;
                default:    op = 7'($urandom_range(0, 127));
            endcase
            i12 = 12'($urandom);
            if ($urandom_range(0, 1) == 1) i12[11:5] = 7'd0;
            r1 = $urandom;
            r2 = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
            run_txn(op, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                    r1, r2, {{20{i12[11]}}, i12}, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
